// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch port between instr_sequencer (master) and instruction memory (slave).
// Handshake: master raises imem_req with imem_addr and holds both stable until a cycle with imem_ack=1;
// the word on imem_rdata transfers on that rising edge, and imem_ack is ignored while imem_req is low.
interface instr_sequencer_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [19:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/branch sequencer for the 8-bit register-file/ALU datapath.
// Four-state FSM (IDLE/FETCH/EXEC/HALT); decode is combinational from the instruction register.
module instr_sequencer (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  instr_sequencer_if.master        imem,
  input  logic                     Zero,
  output logic [3:0]               RA1,
  output logic [3:0]               RA2,
  output logic [3:0]               WA,
  output logic [7:0]               immediate,
  output logic                     write_enable,
  output logic                     ALUSrc,
  output logic [1:0]               ALUControl,
  output logic [7:0]               pc,
  output logic                     halted,
  output logic [15:0]              retired,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [19:0] ir;
  logic        req_q;

  logic [3:0]  op;
  logic [3:0]  fld_a;
  logic [3:0]  fld_rs1;
  logic [7:0]  fld_low;
  logic        in_exec;
  logic        is_reg_alu;
  logic        is_imm_alu;
  logic        is_branch;
  logic        take_target;
  logic [7:0]  next_pc;

  assign op      = ir[19:16];
  assign fld_a   = ir[15:12];
  assign fld_rs1 = ir[11:8];
  assign fld_low = ir[7:0];

  assign in_exec    = (state == S_EXEC);
  assign is_reg_alu = (op[3:2] == 2'b00);
  assign is_imm_alu = (op[3:2] == 2'b01);
  assign is_branch  = (op == 4'h8) || (op == 4'h9);

  // Zero arrives combinationally from the datapath within the EXEC cycle.
  assign take_target = ((op == 4'h8) &&  Zero) ||
                       ((op == 4'h9) && !Zero) ||
                       (op == 4'hA);
  assign next_pc     = take_target ? fld_low : (pc + 8'd1);

  always_comb begin
    WA           = fld_a;
    RA1          = fld_rs1;
    RA2          = fld_low[7:4];
    immediate    = fld_low;
    ALUControl   = 2'b00;
    ALUSrc       = 1'b0;
    write_enable = 1'b0;
    if (is_reg_alu || is_imm_alu) begin
      ALUControl   = op[1:0];
      ALUSrc       = in_exec && is_imm_alu;
      write_enable = in_exec;
    end else if (is_branch) begin
      RA2        = fld_a;
      ALUControl = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= 8'd0;
      ir      <= 20'd0;
      req_q   <= 1'b0;
      halted  <= 1'b0;
      retired <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem.imem_ack) begin
            ir    <= imem.imem_rdata;
            state <= S_EXEC;
            req_q <= 1'b0;
          end
        end
        S_EXEC: begin
          if (retired != 16'hFFFF) begin
            retired <= retired + 16'd1;
          end
          // HALT retires but leaves pc pointing at itself.
          if (op == 4'hF) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
            req_q <= 1'b1;
            pc    <= next_pc;
          end
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;
  assign state_dbg      = state;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Control-side counterpart to the 8-bit register-file/ALU datapath: fetches 20-bit instructions from an external instruction memory over a req/ack handshake and decodes them into that datapath's register addresses, immediate, write enable, ALUSrc and ALUControl. It keeps an 8-bit program counter, resolves conditional branches from the datapath's Zero flag, and stops on HALT. It sits between instruction memory and the datapath; `cpu_out` observation stays in the datapath.

## Interface
- No parameters; all widths fixed: 8-bit data/PC, 4-bit register addresses, 20-bit instruction.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `run` input 1: start request, sampled only in IDLE.
- `imem_req` output 1: fetch request, high throughout FETCH.
- `imem_addr` output 8: fetch address, equal to `pc`.
- `imem_ack` input 1: memory has valid `imem_rdata` this cycle.
- `imem_rdata` input 20: instruction word.
- `Zero` input 1: datapath ALU result equals zero (combinational).
- `RA1`, `RA2`, `WA` output 4 each: datapath register addresses.
- `immediate` output 8: datapath immediate.
- `write_enable` output 1: datapath register write strobe.
- `ALUSrc` output 1: 1 selects the immediate as SrcB.
- `ALUControl` output 2: 00 AND, 01 OR, 10 ADD, 11 SUB.
- `pc` output 8: current program counter.
- `halted` output 1: high in HALT.
- `retired` output 16: count of completed instructions.

## Operation
- Fields: op=[19:16], a=[15:12], rs1=[11:8], low=[7:0].
- op 0-3, register ALU: `WA`=a, `RA1`=rs1, `RA2`=low[7:4], `ALUSrc`=0, `ALUControl`=op[1:0], `write_enable`=1.
- op 4-7, immediate ALU: `WA`=a, `RA1`=rs1, `immediate`=low, `ALUSrc`=1, `ALUControl`=op[1:0], `write_enable`=1.
- op 8 BEQ / op 9 BNE: `RA1`=rs1, `RA2`=a, `ALUSrc`=0, `ALUControl`=11, `write_enable`=0. Branch is taken when `Zero`=1 for BEQ and when `Zero`=0 for BNE. Target is absolute, low.
- op A JMP: next pc = low; `write_enable`=0.
- op F HALT: enter HALT; `write_enable`=0.
- All other ops are NOPs with `write_enable`=0.
- The datapath ignores writes to address 0; the sequencer does not filter them.
- State IDLE: `run`=1 moves to FETCH.
- State FETCH: `imem_req`=1. On an edge with `imem_ack`=1, latch `imem_rdata` into the instruction register and move to EXEC. Otherwise stay in FETCH, with `imem_addr` held stable.
- State EXEC: lasts exactly 1 cycle. The decode outputs are driven combinationally from the instruction register. On the closing edge:
  - `pc` updates to the branch/jump target or to pc+1 (mod 256; 255 wraps to 0).
  - `retired` increments, saturating at 0xFFFF.
  - Next state is FETCH, or HALT for op F.
- HALT does not advance `pc`. HALT counts as retired.
- State HALT: terminal; `halted`=1. Only `reset` leaves it; `run` is ignored.
- Outside EXEC: `write_enable`=0 and `ALUSrc`=0. `RA1`, `RA2`, `WA`, `immediate` and `ALUControl` hold the decode of the last latched instruction; their values are don't-care to the datapath.
- `imem_ack` outside FETCH is ignored.

## Timing
- Reset values: state IDLE, `pc`=0, instruction register=0, `imem_req`=0, `imem_addr`=0, `write_enable`=0, `ALUSrc`=0, `RA1`/`RA2`/`WA`=0, `immediate`=0, `ALUControl`=00, `halted`=0, `retired`=0.
- Reset asserted mid-FETCH or mid-EXEC: `imem_req` and `write_enable` drop asynchronously, and no register write or pc update occurs.
- Minimum instruction time is 2 cycles (FETCH with `imem_ack` in its first cycle, then EXEC). Each cycle FETCH waits for `imem_ack` adds 1 cycle.
- `imem_req` rises in the cycle after the IDLE→FETCH edge.
- Zero→branch is a combinational path within the EXEC cycle; `Zero` is sampled on the EXEC closing edge.
- The datapath register write and the sequencer pc update commit on the same edge.

## Test plan
- Reset, then `run`; instr 0x61205 (ADDI r1=r2+5) with immediate `imem_ack`: `imem_addr`=0 in FETCH; EXEC cycle shows `WA`=1, `RA1`=2, `immediate`=5, `ALUSrc`=1, `ALUControl`=10, `write_enable`=1; then `pc`=1, `retired`=1.
- Hold `imem_ack` low for 3 cycles: `imem_req` stays high and `imem_addr` stable for 4 cycles; EXEC occurs exactly once; `write_enable` never pulses early.
- BEQ 0x83140 with `Zero`=1: `ALUControl`=11, `write_enable`=0, next `pc`=0x40. The same instruction with `Zero`=0 gives next `pc`=old+1. BNE gives the inverse results.
- `pc`=0xFF executing an ADD: next `pc`=0x00. JMP 0xA00C8: next `pc`=0xC8.
- HALT 0xF0000: `halted`=1 from the next cycle; `imem_req` stays 0 and `pc` frozen over 10 cycles even with `run`=1; `retired` incremented once.
- `reset` pulsed mid-FETCH and mid-EXEC: outputs go to reset values within the same cycle, with no `write_enable` pulse; after `run`, fetch restarts at 0.
